mem_stage_ws: RTL
=================

// Module: mem_stage_ws
// PURPOSE
//   Parametrised data-memory access stage for the MIPS pipeline MEM slot.
//   Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
//   Models a slow RAM with a configurable number of wait states and raises stall to freeze the pipeline.
//   Flags misaligned accesses instead of performing them.
// PARAMETERS
//   DEPTH_LOG2   8   log2 of the number of 32-bit words (word index = alu_result[DEPTH_LOG2+1:2])
//   WAIT_STATES  1   extra busy cycles per access, 0..15
// PORTS
//   clk          in   1   clock; all state updates on the rising edge
//   reset        in   1   synchronous, active-high
//   alu_result   in   32  byte address; bits above DEPTH_LOG2+1 are ignored (aliasing)
//   write_data   in   32  store data, right-justified for sub-word stores
//   MemRead      in   1   load request
//   MemWrite     in   1   store request
//   mem_size     in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   mem_unsigned in   1   1: zero-extend sub-word loads; 0: sign-extend
//   read_data    out  32  load result; valid only while done=1, else 0
//   done         out  1   access complete this cycle (DONE state)
//   stall        out  1   pipeline must hold MEM inputs stable
//   misaligned   out  1   current request is misaligned (combinational)
// BEHAVIOUR
//   - Reset is synchronous and active-high on clk.
//   - Reset effects: state <- IDLE, counter <- 0, capture register <- 0, all memory words <- 0.
//   - Outputs after reset: read_data=0, done=0, stall=0, misaligned follows the inputs.
//   - req = MemRead | MemWrite. If both are high, the access is a write; read_data stays 0 at done.
//   - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Flag valid in IDLE only.
//   - A misaligned request is dropped: no memory access, no stall, state remains IDLE.
//   - FSM states are IDLE, BUSY and DONE.
//   - IDLE, aligned req: stall=1 (combinational). Load cnt<=WAIT_STATES; go to BUSY.
//   - BUSY: stall=1. If cnt!=0, cnt<=cnt-1.
//   - BUSY with cnt==0: perform the store, or capture the extended load into a register; go to DONE.
//   - DONE: stall=0, done=1, read_data=captured value. Unconditionally go to IDLE.
//   - Requests seen in DONE are not re-triggered: the pipeline advances at this edge.
//   - Latency: stall is high for exactly WAIT_STATES+2 cycles; done follows in the next cycle.
//   - Inputs are sampled only at the BUSY(cnt==0) edge. The pipeline holds them stable while stall=1.
//   - Byte lanes are little-endian: lane k = word[8k+7:8k], selected by addr[1:0].
//   - Byte store writes write_data[7:0] to lane addr[1:0]; the other lanes are unchanged.
//   - Half store writes write_data[15:0] to lanes {addr[1],1}:{addr[1],0}; the other half is unchanged.
//   - Word store writes the full word.
//   - Loads extract the same lanes as stores.
//   - Byte and half loads extend to 32 bits from bit 7 or bit 15 per mem_unsigned; word loads are unaffected.
//   - Reset mid-access returns to IDLE and stall drops in the next cycle. A store not yet committed is lost.
//   - With WAIT_STATES=0, BUSY lasts one cycle, so stall is high for 2 cycles.
// TESTING
//   T1 SW 0xDEADBEEF @0x10, then LW @0x10 with WAIT_STATES=1:
//      stall is high for 3 cycles; at done, read_data=0xDEADBEEF.
//   T2 SB 0x80 @0x11, then LB @0x11 -> 0xFFFFFF80; LBU @0x11 -> 0x00000080.
//      LW @0x10 -> 0xDEAD80EF.
//   T3 SH 0x1234 @0x16, then LH @0x16 -> 0x00001234. LW @0x14 returns 0x1234 in the upper half.
//   T4 LW @0x12 and LH @0x13: misaligned=1, stall=0, state remains IDLE.
//      A following LW @0x10 is unchanged.
//   T5 Assert reset during BUSY of SW 0x55 @0x20: stall=0 in the next cycle.
//      A later LW @0x20 returns 0x00000000.
//   T6 MemRead=MemWrite=1, SW 0xA5A5A5A5 @0x30: read_data=0 at done. A later LW @0x30 -> 0xA5A5A5A5.

Source files
------------

// File: rtl/mem_stage_ws.sv
// ---------------------------------------------------------------------------
// mem_stage_ws
//   Data-memory access stage for the MEM slot of a MIPS pipeline. Performs
//   byte, halfword and word loads/stores on a little-endian word array, with
//   sign or zero extension of sub-word loads. The RAM is modelled as slow:
//   every aligned access spends WAIT_STATES extra busy cycles, and stall is
//   raised so the pipeline holds the MEM inputs stable until the access ends.
//   Misaligned requests are flagged and dropped without touching memory.
//
// Parameters
//   DEPTH_LOG2   log2 of the number of 32-bit words in the array
//   WAIT_STATES  extra busy cycles per access (0..15)
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         synchronous, active-high
//   alu_result    byte address (upper bits alias)
//   write_data    store data, right-justified for sub-word stores
//   MemRead       load request
//   MemWrite      store request (wins over MemRead when both are high)
//   mem_size      00 byte, 01 half, 10/11 word
//   mem_unsigned  1: zero-extend sub-word loads, 0: sign-extend
//   read_data     load result while done=1, otherwise 0
//   done          access completes this cycle
//   stall         pipeline must hold the MEM inputs
//   misaligned    current request is misaligned (combinational, IDLE only)
// ---------------------------------------------------------------------------
module mem_stage_ws #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic [31:0] read_data,
    output logic        done,
    output logic        stall,
    output logic        misaligned
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic [31:0]           cap;
    logic [31:0]           mem [0:DEPTH-1];

    logic                  req;
    logic                  addr_bad;
    logic [DEPTH_LOG2-1:0] widx;
    logic [1:0]            lane;

    // Extract the addressed lane(s) of a word and extend to 32 bits.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  ln,
        input logic [1:0]  size,
        input logic        uns
    );
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [31:0] ext;
        b = word[{ln, 3'b000} +: 8];
        h = word[{ln[1], 4'b0000} +: 16];
        case (size)
            2'b00:   ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: ext = word;
        endcase
        return ext;
    endfunction

    // Merge right-justified store data into the addressed lane(s) of a word.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  ln,
        input logic [1:0]  size
    );
        logic [31:0] res;
        res = word;
        case (size)
            2'b00:   res[{ln, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   res[{ln[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    assign req  = MemRead | MemWrite;
    assign widx = alu_result[DEPTH_LOG2+1:2];
    assign lane = alu_result[1:0];

    // mem_size 11 is treated as a word, so bit 1 alone selects word alignment.
    assign addr_bad = ((mem_size == 2'b01) && alu_result[0]) ||
                      (mem_size[1] && (alu_result[1:0] != 2'b00));

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        misaligned = 1'b0;
        read_data  = 32'd0;
        case (state)
            IDLE: begin
                misaligned = req && addr_bad;
                if (req && !addr_bad) begin
                    stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // The pipeline advances at this edge, so a request still
                // present now belongs to the completed access.
                done       = 1'b1;
                read_data  = cap;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            cap   <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req && !addr_bad) begin
                        cnt <= 4'(WAIT_STATES);
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (MemWrite) begin
                        // A combined read/write request is a store and
                        // returns 0 at done.
                        mem[widx] <= store_merge(mem[widx], write_data, lane, mem_size);
                        cap       <= 32'd0;
                    end else if (MemRead) begin
                        cap <= load_extend(mem[widx], lane, mem_size, mem_unsigned);
                    end else begin
                        cap <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
